// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------
// run_ctrl -- run-control and retirement monitor for the MIPS core.
//
// Watches the in-order retirement stream and counts cycles and retired
// instructions. It detects the end of the program in one of three ways:
//   - a halt instruction retires: wait DRAIN_CYCLES, then halt;
//   - the cycle counter reaches MAX_CYCLES: timeout, halt at once;
//   - optionally, the same PC retires LOOP_THRESH times in a row.
// Once halted, the core is frozen and the status stays put until reset.
//
// Optional feature: define RUN_CTRL_SELF_LOOP_EN to build the self-loop
// detector. Without it, cause 2'b11 never occurs and LOOP_THRESH is unused.
// ---------------------------------------------------------------------------
module run_ctrl #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MAX_CYCLES   = 750,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_INSTR   = 32'h0000000C,
    parameter int unsigned LOOP_THRESH  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire_valid,
    input  logic [31:0]      retire_pc,
    input  logic [31:0]      retire_instr,
    output logic             core_freeze,
    output logic             halted,
    output logic             done,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_HALT    = 2'b01,
        CAUSE_TIMEOUT = 2'b10,
        CAUSE_LOOP    = 2'b11
    } cause_e;

    // The drain counter needs at least one bit, even when DRAIN_CYCLES is
    // 0 or 1. When DRAIN_CYCLES is 0 the load value is never used.
    localparam int unsigned        DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_W'(DRAIN_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0]   TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);

    state_e             r_state;
    cause_e             r_cause;
    logic               r_core_freeze;
    logic               r_halted;
    logic               r_done;
    logic [CNT_W-1:0]   r_cycle_count;
    logic [CNT_W-1:0]   r_instr_count;
    logic [DRAIN_W-1:0] r_drain_cnt;

    logic               w_halt_hit;
    logic               w_timeout_hit;
    logic               w_loop_hit;
    logic [CNT_W-1:0]   w_cycle_inc;
    logic [CNT_W-1:0]   w_instr_inc;

    // Saturating increments: once a counter reaches all-ones it stays there.
    assign w_cycle_inc   = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + 1'b1;
    assign w_instr_inc   = (r_instr_count == '1) ? r_instr_count : r_instr_count + 1'b1;
    assign w_halt_hit    = retire_valid && (retire_instr == HALT_INSTR);
    assign w_timeout_hit = (r_cycle_count == TIMEOUT_AT);

`ifdef RUN_CTRL_SELF_LOOP_EN
    // The repeat counter never needs to count past LOOP_THRESH, because the
    // state leaves RUN as soon as it gets there.
    localparam int unsigned REP_W = (LOOP_THRESH > 0) ? $clog2(LOOP_THRESH + 1) : 1;

    logic [31:0]      r_last_pc;
    logic [REP_W-1:0] r_repeat;
    logic [REP_W-1:0] w_repeat_next;

    // Next repeat count. The reset value of r_repeat is 0, so the first
    // retirement gives 1 whether or not its PC matches r_last_pc. That means
    // no separate "last PC is valid" flag is needed.
    always_comb begin
        w_repeat_next = r_repeat;
        if (retire_valid) begin
            w_repeat_next = (retire_pc == r_last_pc) ? r_repeat + 1'b1 : REP_W'(1);
        end
    end

    assign w_loop_hit = retire_valid && (w_repeat_next == REP_W'(LOOP_THRESH));

    // Track the last retired PC and how many times it has repeated.
    // Both only update while in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_pc <= '0;
            r_repeat  <= '0;
        end else if ((r_state == ST_RUN) && retire_valid) begin
            r_last_pc <= retire_pc;
            r_repeat  <= w_repeat_next;
        end
    end
`else
    logic [31:0] w_unused_loop;

    assign w_loop_hit    = 1'b0;
    assign w_unused_loop = retire_pc ^ 32'(LOOP_THRESH);
`endif

    // Main FSM. All status outputs are registered here.
    // NOTE: sequential state uses non-blocking assignments only. Each
    // register then sees the values from before the edge, with no
    // dependence on the order of the statements.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-high. It is sampled only on
        // the clock edge, so it is not in the sensitivity list.
        if (reset) begin
            r_state       <= ST_RUN;
            r_cause       <= CAUSE_NONE;
            r_core_freeze <= 1'b0;
            r_halted      <= 1'b0;
            r_done        <= 1'b0;
            r_cycle_count <= '0;
            r_instr_count <= '0;
            r_drain_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_cycle_count <= w_cycle_inc;
                    // A halt instruction is itself counted as retired.
                    if (retire_valid) begin
                        r_instr_count <= w_instr_inc;
                    end
                    // Priority: halt instruction > self-loop > timeout.
                    if (w_halt_hit) begin
                        r_cause <= CAUSE_HALT;
                        if (DRAIN_CYCLES == 0) begin
                            r_state       <= ST_HALTED;
                            r_halted      <= 1'b1;
                            r_core_freeze <= 1'b1;
                            r_done        <= 1'b1;
                        end else begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= DRAIN_LOAD;
                        end
                    end else if (w_loop_hit) begin
                        r_cause       <= CAUSE_LOOP;
                        r_state       <= ST_HALTED;
                        r_halted      <= 1'b1;
                        r_core_freeze <= 1'b1;
                        r_done        <= 1'b1;
                    end else if (w_timeout_hit) begin
                        r_cause       <= CAUSE_TIMEOUT;
                        r_state       <= ST_HALTED;
                        r_halted      <= 1'b1;
                        r_core_freeze <= 1'b1;
                        r_done        <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    // Wait for writebacks still in flight. Retirements and
                    // the timeout are both ignored here.
                    r_cycle_count <= w_cycle_inc;
                    if (r_drain_cnt == '0) begin
                        r_state       <= ST_HALTED;
                        r_halted      <= 1'b1;
                        r_core_freeze <= 1'b1;
                        r_done        <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end

                ST_HALTED: begin
                    // Terminal state: done was a one-cycle pulse on entry.
                    r_done <= 1'b0;
                end

                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign core_freeze = r_core_freeze;
    assign halted      = r_halted;
    assign done        = r_done;
    assign cause       = r_cause;
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_run_ctrl -- directed, self-checking bench for run_ctrl.
//
// Two instances share one stimulus stream:
//   u_dut_a: MAX_CYCLES=20, DRAIN_CYCLES=4
//   u_dut_b: MAX_CYCLES=10, DRAIN_CYCLES=4 (timeout and halt on the same cycle)
// Expected values are computed by hand for each step. Inputs change 1 ns
// after a rising edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_run_ctrl;

    localparam int          CNT_W = 32;
    localparam logic [31:0] HALT  = 32'h0000000C;
    localparam logic [31:0] NOP   = 32'h20080001;  // addi $t0,$zero,1

    logic             clk;
    logic             reset;
    logic             retire_valid;
    logic [31:0]      retire_pc;
    logic [31:0]      retire_instr;

    logic             a_freeze, a_halted, a_done;
    logic [1:0]       a_cause;
    logic [CNT_W-1:0] a_cycles, a_instrs;
    logic             b_freeze, b_halted, b_done;
    logic [1:0]       b_cause;
    logic [CNT_W-1:0] b_cycles, b_instrs;

    int checks   = 0;
    int failures = 0;

    run_ctrl #(.CNT_W(CNT_W), .MAX_CYCLES(20), .DRAIN_CYCLES(4),
               .HALT_INSTR(32'h0000000C), .LOOP_THRESH(3)) u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_instr (retire_instr),
        .core_freeze  (a_freeze),
        .halted       (a_halted),
        .done         (a_done),
        .cause        (a_cause),
        .cycle_count  (a_cycles),
        .instr_count  (a_instrs)
    );

    run_ctrl #(.CNT_W(CNT_W), .MAX_CYCLES(10), .DRAIN_CYCLES(4),
               .HALT_INSTR(32'h0000000C), .LOOP_THRESH(3)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_instr (retire_instr),
        .core_freeze  (b_freeze),
        .halted       (b_halted),
        .done         (b_done),
        .cause        (b_cause),
        .cycle_count  (b_cycles),
        .instr_count  (b_instrs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic h, input logic d, input logic [1:0] c,
                         input logic [CNT_W-1:0] cy, input logic [CNT_W-1:0] ic);
        check({tag, ".a_halted"}, 64'(a_halted), 64'(h));
        check({tag, ".a_freeze"}, 64'(a_freeze), 64'(h));
        check({tag, ".a_done"},   64'(a_done),   64'(d));
        check({tag, ".a_cause"},  64'(a_cause),  64'(c));
        check({tag, ".a_cycles"}, 64'(a_cycles), 64'(cy));
        check({tag, ".a_instrs"}, 64'(a_instrs), 64'(ic));
    endtask

    task automatic chk_b(input string tag, input logic h, input logic d, input logic [1:0] c,
                         input logic [CNT_W-1:0] cy, input logic [CNT_W-1:0] ic);
        check({tag, ".b_halted"}, 64'(b_halted), 64'(h));
        check({tag, ".b_freeze"}, 64'(b_freeze), 64'(h));
        check({tag, ".b_done"},   64'(b_done),   64'(d));
        check({tag, ".b_cause"},  64'(b_cause),  64'(c));
        check({tag, ".b_cycles"}, 64'(b_cycles), 64'(cy));
        check({tag, ".b_instrs"}, 64'(b_instrs), 64'(ic));
    endtask

    // Advance one rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        retire_valid = v;
        retire_pc    = pc;
        retire_instr = instr;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0);

        // ---- Reset state
        do_reset();
        chk_a("rst", 1'b0, 1'b0, 2'b00, 0, 0);
        chk_b("rst", 1'b0, 1'b0, 2'b00, 0, 0);

        // ---- T1: five retirements, the fifth is a halt; then a 4-cycle drain
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(4 * i), (i == 4) ? HALT : NOP);
            step();
        end
        chk_a("t1_halt_edge", 1'b0, 1'b0, 2'b01, 5, 5);
        drive(1'b0, 32'h0, 32'h0);
        step(); step(); step();
        chk_a("t1_drain3", 1'b0, 1'b0, 2'b01, 8, 5);
        step();
        chk_a("t1_halted", 1'b1, 1'b1, 2'b01, 9, 5);
        step();
        chk_a("t1_after", 1'b1, 1'b0, 2'b01, 9, 5);

        // ---- T6: after HALTED, inputs are ignored for 10 cycles
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h200, HALT);
            step();
            check("t6_done_low", 64'(a_done), 64'(0));
        end
        chk_a("t6_hold", 1'b1, 1'b0, 2'b01, 9, 5);
        drive(1'b0, 32'h0, 32'h0);

        // ---- T2: timeout on A (MAX=20) with a non-halt retirement every cycle
        do_reset();
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, 32'(4 * i), NOP);
            step();
        end
        chk_a("t2_edge19", 1'b0, 1'b0, 2'b00, 19, 19);
        drive(1'b1, 32'(4 * 19), NOP);
        step();
        chk_a("t2_timeout", 1'b1, 1'b1, 2'b10, 20, 20);
        drive(1'b1, 32'(4 * 20), NOP);
        step();
        chk_a("t2_hold", 1'b1, 1'b0, 2'b10, 20, 20);
        drive(1'b0, 32'h0, 32'h0);

        // ---- T3: on B (MAX=10), a halt retires on cycle index 9 and beats the timeout
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'(4 * i), NOP);
            step();
        end
        drive(1'b1, 32'h24, HALT);
        step();
        chk_b("t3_halt_edge", 1'b0, 1'b0, 2'b01, 10, 10);
        drive(1'b0, 32'h0, 32'h0);
        step(); step(); step();
        chk_b("t3_drain3", 1'b0, 1'b0, 2'b01, 13, 10);
        step();
        chk_b("t3_halted", 1'b1, 1'b1, 2'b01, 14, 10);

        // ---- T4: reset in the middle of DRAIN, then a normal halt
        do_reset();
        drive(1'b1, 32'h0, NOP);  step();
        drive(1'b1, 32'h4, NOP);  step();
        drive(1'b1, 32'h8, HALT); step();
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk_a("t4_drain1", 1'b0, 1'b0, 2'b01, 4, 3);
        reset = 1'b1;
        drive(1'b1, 32'hC, HALT);  // this retirement must not be counted
        step();
        chk_a("t4_reset", 1'b0, 1'b0, 2'b00, 0, 0);
        reset = 1'b0;
        drive(1'b1, 32'h100, HALT);
        step();
        chk_a("t4_rehalt", 1'b0, 1'b0, 2'b01, 1, 1);
        drive(1'b0, 32'h0, 32'h0);
        step(); step(); step();
        check("t4_drain_halted", 64'(a_halted), 64'(0));
        step();
        chk_a("t4_halted", 1'b1, 1'b1, 2'b01, 5, 1);

        // ---- T5: the same PC retires repeatedly
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h40, NOP);
            step();
        end
`ifdef RUN_CTRL_SELF_LOOP_EN
        chk_a("t5_loop", 1'b1, 1'b1, 2'b11, 3, 3);
`else
        chk_a("t5_noloop", 1'b0, 1'b0, 2'b00, 3, 3);
        for (int i = 3; i < 19; i++) begin
            drive(1'b1, 32'h40, NOP);
            step();
        end
        chk_a("t5_edge19", 1'b0, 1'b0, 2'b00, 19, 19);
        drive(1'b1, 32'h40, NOP);
        step();
        chk_a("t5_timeout", 1'b1, 1'b1, 2'b10, 20, 20);
`endif
        drive(1'b0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Run-control and retirement monitor directly downstream of the MIPS core top (Main).
- Consumes the core's in-order retirement stream, counts cycles and retired instructions, and detects program end: halt instruction, cycle timeout, or optional self-loop.
- Drives a freeze back into the core and a done/halted status that benches use instead of fixed-time stops.

Parameters:
- CNT_W, 32, width of cycle and instruction counters
- MAX_CYCLES, 750, timeout limit in cycles (matches the current 1500 ns bench window at a 2 ns clock)
- DRAIN_CYCLES, 4, cycles waited after the halt instruction retires so in-flight writebacks complete
- HALT_INSTR, 32'h0000000C, encoding treated as halt (MIPS syscall)
- LOOP_THRESH, 3, consecutive same-PC retirements that count as a self-loop (used only with the optional feature)

Ports:
- clk  in  1  core clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- retire_valid  in  1  one instruction retires this cycle
- retire_pc  in  32  PC of the retiring instruction
- retire_instr  in  32  encoding of the retiring instruction
- core_freeze  out  1  holds the core (PC and pipeline registers) when 1
- halted  out  1  level, high in HALTED
- done  out  1  one-cycle pulse on entry to HALTED
- cause  out  2  00 none, 01 halt instruction, 10 timeout, 11 self-loop
- cycle_count  out  CNT_W  cycles spent in RUN+DRAIN
- instr_count  out  CNT_W  instructions accepted as retired

Behaviour:
- All outputs are registered. Reset values: core_freeze=0, halted=0, done=0, cause=00, counters=0, state=RUN.
- States: RUN, DRAIN, HALTED.
- RUN, cycle count: cycle_count increments by 1 every cycle.
- RUN, instruction count: instr_count increments on each cycle with retire_valid=1.
- RUN -> DRAIN: when retire_valid=1 and retire_instr==HALT_INSTR.
  - cause<=01 on the same edge.
  - The halt instruction itself is counted in instr_count.
  - A drain counter loads DRAIN_CYCLES-1.
- RUN -> HALTED (timeout): when cycle_count==MAX_CYCLES-1 with no halt retiring that cycle. cause<=10.
- Simultaneous halt retire and timeout: the halt wins. Go to DRAIN with cause=01.
- DRAIN:
  - cycle_count keeps incrementing.
  - retire_valid is ignored; instr_count is frozen.
  - Timeout is ignored.
  - When the drain counter reaches 0, go to HALTED. DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- DRAIN_CYCLES==0: RUN goes directly to HALTED on halt retire.
- HALTED:
  - halted=1 and core_freeze=1, asserted on the entry edge.
  - done=1 for exactly the first HALTED cycle.
  - Counters and cause hold.
  - Inputs are ignored; the state is left only by reset.
- Counters saturate at all-ones and never wrap.
- Reset in any state, including mid-DRAIN, returns to reset values on the next edge. A retirement in the reset cycle is not counted.
- retire_pc and retire_instr are don't-care when retire_valid=0.

Optional Feature:
- Macro: RUN_CTRL_SELF_LOOP_EN.
- When defined:
  - A last-PC register and a repeat counter are instantiated.
  - In RUN, each retirement with retire_pc equal to the previously retired PC increments the repeat counter; a retirement with a different PC resets it to 1.
  - Non-retire cycles leave both unchanged.
  - When the repeat count reaches LOOP_THRESH, go to HALTED with cause=11 (covers "j ." / "beq $0,$0,-1" program ends).
  - Priority when events coincide: halt instruction > self-loop > timeout.
- When undefined: no loop logic is built, cause 11 never occurs, and LOOP_THRESH is unused.

Test Plan:
1. Reset, then retire 5 instructions at PCs 0,4,…,16, with the 5th = 32'h0000000C -> DRAIN for 4 cycles, then halted=1, done pulses once, cause=01, instr_count=5, core_freeze=1.
2. MAX_CYCLES=20, retire a non-halt instruction every cycle -> on edge 20: halted=1, cause=10, cycle_count=20, instr_count=20.
3. MAX_CYCLES=10, halt instruction retires exactly on cycle index 9 -> cause=01, DRAIN entered, no timeout, halted 4 cycles later.
4. Reset asserted for 1 cycle mid-DRAIN (2nd drain cycle) -> all outputs 0, state RUN; a subsequent halt instruction halts normally with instr_count counted from 0.
5. With RUN_CTRL_SELF_LOOP_EN: retire PC 0x40 three consecutive times -> halted, cause=11, instr_count includes all 3. Without the macro, the same stimulus runs until timeout with cause=10.
6. After HALTED: retire_valid=1 with the halt encoding for 10 cycles -> counters and cause unchanged, done stays 0.
